// File: rtl/ifmap_bank_reader_if.sv
// Bus bundle between the ifmap bank reader and its surroundings: configuration,
// bank handshake with the write controller, memory read port and output stream.
interface ifmap_bank_reader_if #(
    parameter int unsigned IC0             = 2,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned CONFIG_WIDTH    = 32,
    parameter int unsigned BANK_ADDR_WIDTH = 32
);
    logic                       config_en;
    logic [CONFIG_WIDTH-1:0]    config_data;
    logic                       bank_ready;
    logic                       bank_release;
    logic                       rd_en;
    logic [BANK_ADDR_WIDTH-1:0] rd_addr;
    logic [IC0*DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH-1:0]      output_dat;
    logic                       output_vld;
    logic                       output_rdy;
    logic                       done;

    // Reader side.
    modport master (
        input  config_en, config_data, bank_ready, rd_data, output_rdy,
        output bank_release, rd_en, rd_addr, output_dat, output_vld, done
    );

    // Environment side: config source, write controller, memory and consumer.
    modport slave (
        output config_en, config_data, bank_ready, rd_data, output_rdy,
        input  bank_release, rd_en, rd_addr, output_dat, output_vld, done
    );
endinterface

// File: rtl/ifmap_bank_reader.sv
// Ifmap bank reader: fetches IC0-lane chained words from the bank memory and
// emits them lane by lane (lane 0 first) as a DATA_WIDTH valid/ready stream,
// walking OY1_OX1 banks of D words and handshaking each bank with the writer.
module ifmap_bank_reader #(
    parameter int unsigned IC0             = 2,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned COUNTER_WID     = 8,
    parameter int unsigned CONFIG_WIDTH    = 32,
    parameter int unsigned BANK_ADDR_WIDTH = 32,
    parameter int unsigned OY1_OX1         = 2
) (
    input  logic                clk,
    input  logic                rst,
    ifmap_bank_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        FETCH,
        STREAM,
        RELEASE,
        DONE
    } state_t;

    state_t                     state;
    logic [COUNTER_WID-1:0]     depth;
    logic [COUNTER_WID-1:0]     bank_idx;
    logic [COUNTER_WID-1:0]     word_idx;
    logic [COUNTER_WID-1:0]     lane_idx;
    logic [BANK_ADDR_WIDTH-1:0] base;
    logic [IC0*DATA_WIDTH-1:0]  hold;
    logic [DATA_WIDTH-1:0]      lane_dat;

    logic cfg_ok;
    logic last_lane;
    logic last_word;
    logic last_bank;
    logic handshake;

    assign cfg_ok    = bus.config_en && (bus.config_data != '0);
    assign last_lane = (lane_idx == COUNTER_WID'(IC0 - 1));
    assign last_word = (word_idx == depth - COUNTER_WID'(1));
    assign last_bank = (bank_idx == COUNTER_WID'(OY1_OX1 - 1));
    assign handshake = (state == STREAM) && bus.output_rdy;

    // Select the current lane out of the holding register.
    always_comb begin
        lane_dat = '0;
        for (int unsigned i = 0; i < IC0; i++) begin
            if (lane_idx == COUNTER_WID'(i)) begin
                lane_dat = hold[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read strobe: on bank grant, or on the last-lane handshake so the next word
    // arrives after a single bubble cycle.
    always_comb begin
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        if ((state == WAIT_BANK) && bus.bank_ready) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = base;
        end else if (handshake && last_lane && !last_word) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = base + BANK_ADDR_WIDTH'(word_idx) + BANK_ADDR_WIDTH'(1);
        end
    end

    assign bus.output_vld   = (state == STREAM);
    assign bus.output_dat   = (state == STREAM) ? lane_dat : '0;
    assign bus.bank_release = (state == RELEASE);
    assign bus.done         = (state == DONE);

    // Control FSM with word/lane/bank counters and bank base address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            depth    <= '0;
            bank_idx <= '0;
            word_idx <= '0;
            lane_idx <= '0;
            base     <= '0;
            hold     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_ok) begin
                        depth <= bus.config_data[COUNTER_WID-1:0];
                        state <= WAIT_BANK;
                    end
                end
                WAIT_BANK: begin
                    if (bus.bank_ready) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    hold     <= bus.rd_data;
                    lane_idx <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (bus.output_rdy) begin
                        if (!last_lane) begin
                            lane_idx <= lane_idx + COUNTER_WID'(1);
                        end else if (!last_word) begin
                            word_idx <= word_idx + COUNTER_WID'(1);
                            state    <= FETCH;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    word_idx <= '0;
                    if (last_bank) begin
                        base     <= '0;
                        bank_idx <= '0;
                        state    <= DONE;
                    end else begin
                        base     <= base + BANK_ADDR_WIDTH'(depth);
                        bank_idx <= bank_idx + COUNTER_WID'(1);
                        state    <= WAIT_BANK;
                    end
                end
                DONE: begin
                    if (cfg_ok) begin
                        depth <= bus.config_data[COUNTER_WID-1:0];
                        state <= WAIT_BANK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
